// File: rtl/arf_frame_sequencer.sv
// Serial-to-frame sequencer around the combinational ARF datapath: loads operands, settles, captures, hands off.
// Optional macro ARF_FEEDBACK_EN: state operands come from captured results (8-word frames) instead of words 8/9 (10-word frames).
module arf_frame_sequencer #(
    parameter int unsigned W      = 16,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CW     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    input  logic           clear_state,
    output logic [8*W-1:0] arf_in,
    output logic [W-1:0]   arf_in_13_1,
    output logic [W-1:0]   arf_in_14_1,
    input  logic [W-1:0]   arf_out_27,
    input  logic [W-1:0]   arf_out_28,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data_27,
    output logic [W-1:0]   m_data_28,
    output logic           busy,
    output logic [15:0]    frame_cnt
);

`ifdef ARF_FEEDBACK_EN
    localparam int unsigned NW = 8;
`else
    localparam int unsigned NW = 10;
`endif
    localparam int unsigned IW = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept, capture, handshake;
    logic          s_ready_nxt, m_valid_nxt, busy_nxt;
    logic [W-1:0]  slot [NW];

    // Next-state and handshake decode
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        accept      = 1'b0;
        capture     = 1'b0;
        handshake   = 1'b0;
        s_ready_nxt = 1'b1;
        m_valid_nxt = 1'b0;
        busy_nxt    = 1'b0;
        case (state)
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    accept = 1'b1;
                    if (idx == IW'(NW - 1)) begin
                        idx_nxt   = '0;
                        cnt_nxt   = CW'(SETTLE);
                        state_nxt = ST_WAIT;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUT;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_OUT: begin
                if (m_valid && m_ready) begin
                    handshake = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
        // Status outputs are registered from the state being entered
        s_ready_nxt = (state_nxt == ST_LOAD);
        m_valid_nxt = (state_nxt == ST_OUT);
        busy_nxt    = (state_nxt != ST_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            idx       <= '0;
            cnt       <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            m_data_27 <= '0;
            m_data_28 <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            s_ready <= s_ready_nxt;
            m_valid <= m_valid_nxt;
            busy    <= busy_nxt;
            if (capture) begin
                m_data_27 <= arf_out_27;
                m_data_28 <= arf_out_28;
            end
            if (handshake) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Operand slots keep stale values until overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NW); k++) begin
                slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NW); k++) begin
                if (accept && (idx == IW'(k))) begin
                    slot[k] <= s_data;
                end
            end
        end
    end

    always_comb begin
        arf_in = '0;
        for (int k = 0; k < 8; k++) begin
            arf_in[k*W +: W] = slot[k];
        end
    end

`ifdef ARF_FEEDBACK_EN
    logic [W-1:0] state_a, state_b;

    // Recursive state; a clear request overrides the write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_a <= '0;
            state_b <= '0;
        end else if (clear_state) begin
            state_a <= '0;
            state_b <= '0;
        end else if (handshake) begin
            state_a <= m_data_27;
            state_b <= m_data_28;
        end
    end

    assign arf_in_13_1 = state_a;
    assign arf_in_14_1 = state_b;
`else
    logic unused_clear_state;

    assign unused_clear_state = clear_state;
    assign arf_in_13_1        = slot[8];
    assign arf_in_14_1        = slot[9];
`endif

endmodule

// File: tb/tb_arf_frame_sequencer.sv
// Randomized and directed bench for arf_frame_sequencer against a transaction-level frame model.
// Follows the ARF_FEEDBACK_EN setting of the build (8-word frames, SETTLE=2 when defined; 10-word, SETTLE=0 otherwise).
module tb_arf_frame_sequencer;

    localparam int unsigned W = 16;
`ifdef ARF_FEEDBACK_EN
    localparam int unsigned NW        = 8;
    localparam int unsigned TB_SETTLE = 2;
`else
    localparam int unsigned NW        = 10;
    localparam int unsigned TB_SETTLE = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           clear_state = 1'b0;
    logic [8*W-1:0] arf_in;
    logic [W-1:0]   arf_in_13_1, arf_in_14_1;
    logic [W-1:0]   arf_out_27, arf_out_28;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [W-1:0]   m_data_27, m_data_28;
    logic           busy;
    logic [15:0]    frame_cnt;

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    arf_frame_sequencer #(.W(W), .SETTLE(TB_SETTLE), .CW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .clear_state (clear_state),
        .arf_in      (arf_in),
        .arf_in_13_1 (arf_in_13_1),
        .arf_in_14_1 (arf_in_14_1),
        .arf_out_27  (arf_out_27),
        .arf_out_28  (arf_out_28),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data_27   (m_data_27),
        .m_data_28   (m_data_28),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    // Datapath stub
    assign arf_out_27 = arf_in[W-1:0] + arf_in_13_1;
    assign arf_out_28 = arf_in[7*W +: W] + arf_in_14_1;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: words collected, settle cycles left, pending result
    logic [W-1:0] m_slot [NW];
    int           m_fill = 0;
    int           m_wait = -1;
    bit           m_have = 1'b0;
    logic [W-1:0] m_r27 = '0, m_r28 = '0, m_sa = '0, m_sb = '0;
    logic [15:0]  m_frames = '0;
    bit           collecting;

    function automatic logic [W-1:0] op_a();
`ifdef ARF_FEEDBACK_EN
        return m_sa;
`else
        return m_slot[8];
`endif
    endfunction

    function automatic logic [W-1:0] op_b();
`ifdef ARF_FEEDBACK_EN
        return m_sb;
`else
        return m_slot[9];
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NW); k++) m_slot[k] = '0;
            m_fill = 0; m_wait = -1; m_have = 1'b0;
            m_r27 = '0; m_r28 = '0; m_sa = '0; m_sb = '0; m_frames = '0;
        end else begin
            collecting = (m_wait < 0) && !m_have;
            if (collecting && s_valid) begin
                m_slot[m_fill] = s_data;
                m_fill++;
                if (m_fill == int'(NW)) begin
                    m_fill = 0;
                    m_wait = int'(TB_SETTLE);
                end
            end else if (m_wait == 0) begin
                m_r27 = m_slot[0] + op_a();
                m_r28 = m_slot[7] + op_b();
                m_have = 1'b1;
                m_wait = -1;
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (m_have && m_ready) begin
`ifdef ARF_FEEDBACK_EN
                m_sa = m_r27;
                m_sb = m_r28;
`endif
                m_frames = m_frames + 16'd1;
                m_have = 1'b0;
            end
`ifdef ARF_FEEDBACK_EN
            if (clear_state) begin
                m_sa = '0;
                m_sb = '0;
            end
`endif
        end
    end

    // Cycle compare against the model
    always @(negedge clk) begin
        logic [8*W-1:0] exp_arf;
        if (run_chk && !rst) begin
            exp_arf = '0;
            for (int k = 0; k < 8; k++) exp_arf[k*W +: W] = m_slot[k];
            chk("s_ready", s_ready, (m_wait < 0) && !m_have);
            chk("m_valid", m_valid, m_have);
            chk("busy", busy, (m_wait >= 0) || m_have);
            chk("frame_cnt", frame_cnt, m_frames);
            chk("arf_in", arf_in, exp_arf);
            chk("arf_in_13_1", arf_in_13_1, op_a());
            chk("arf_in_14_1", arf_in_14_1, op_b());
            chk("m_data_27", m_data_27, m_r27);
            chk("m_data_28", m_data_28, m_r28);
        end
    end

    // Present one word; it is accepted on the following rising edge
    task automatic put_word(input logic [W-1:0] w);
        int t = 0;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            s_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        s_valid = 1'b1;
        s_data  = w;
    endtask

    task automatic run_frame(input logic [W-1:0] base, input bit mr,
                             input logic [W-1:0] e27, input logic [W-1:0] e28, input string tag);
        int n = 0;
        for (int i = 0; i < int'(NW); i++) put_word(base + W'(i));
        m_ready = mr;
        @(posedge clk);
        #1 s_valid = 1'b0;
        while (!m_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(TB_SETTLE + 1));
        chk({tag, "_d27"}, m_data_27, e27);
        chk({tag, "_d28"}, m_data_28, e28);
    endtask

    task automatic handshake(input logic [15:0] exp_cnt, input string tag);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_hs_s_ready"}, s_ready, 1'b1);
        chk({tag, "_hs_m_valid"}, m_valid, 1'b0);
        chk({tag, "_hs_frame_cnt"}, frame_cnt, exp_cnt);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
    endtask

    initial begin
        logic [8*W-1:0] bp_arf;
        repeat (2) @(negedge clk);
        reset_checks("rst0");
        chk("rst0_arf_in", arf_in, '0);
        chk("rst0_m_data_27", m_data_27, '0);
        rst     = 1'b0;
        run_chk = 1'b1;

`ifdef ARF_FEEDBACK_EN
        run_frame(16'd1, 1'b1, 16'd1, 16'd8, "first");
        handshake(16'd1, "first");
        run_frame(16'd10, 1'b1, 16'd11, 16'd25, "feedback");
        handshake(16'd2, "feedback");

        run_frame(16'd20, 1'b0, 16'd31, 16'd52, "bp");
        bp_arf = '0;
        for (int k = 0; k < 8; k++) bp_arf[k*W +: W] = 16'd20 + W'(k);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_s_ready", s_ready, 1'b0);
            chk("bp_m_valid", m_valid, 1'b1);
            chk("bp_d27", m_data_27, 16'd31);
            chk("bp_arf_in", arf_in, bp_arf);
        end
        handshake(16'd3, "bp");
`else
        run_frame(16'd1, 1'b1, 16'd10, 16'd18, "first");
        handshake(16'd1, "first");
        run_frame(16'd1, 1'b1, 16'd10, 16'd18, "repeat");
        handshake(16'd2, "repeat");
`endif

        // Asynchronous reset in the middle of the settle window
        for (int i = 0; i < int'(NW); i++) put_word(16'd1 + W'(i));
        m_ready = 1'b0;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        reset_checks("async_rst");
        @(negedge clk);
        rst = 1'b0;

`ifdef ARF_FEEDBACK_EN
        run_frame(16'd1, 1'b0, 16'd1, 16'd8, "after_rst");
        @(negedge clk);
        clear_state = 1'b1;
        m_ready     = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
        chk("clear_frame_cnt", frame_cnt, 16'd1);
        run_frame(16'd10, 1'b1, 16'd10, 16'd17, "cleared");
        handshake(16'd2, "cleared");
`else
        run_frame(16'd1, 1'b0, 16'd10, 16'd18, "after_rst");
        @(negedge clk);
        clear_state = 1'b1;
        m_ready     = 1'b1;
        @(posedge clk);
        #1 clear_state = 1'b0;
        chk("clear_frame_cnt", frame_cnt, 16'd1);
        run_frame(16'd1, 1'b1, 16'd10, 16'd18, "clear_ignored");
        handshake(16'd2, "clear_ignored");
`endif

        // Random traffic: gaps, junk while not ready, backpressure, sporadic clears
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = W'($urandom);
            m_ready     = ($urandom_range(0, 2) != 0);
            clear_state = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        s_valid     = 1'b0;
        clear_state = 1'b0;
        m_ready     = 1'b1;
        repeat (20) @(negedge clk);
        chk("random_progress", 128'(frame_cnt > 16'd20), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
